// File: rtl/oh_par2ser_tx.sv
// rtl/oh_par2ser_tx.sv - parallel-to-serial transmit stage with one-word pending buffer
//
// Accepts PW-bit words on a valid/ready handshake and emits them SW bits per
// cycle. A single pending buffer lets the next word be queued while the
// current one shifts, so consecutive words stream with no idle cycle.
//
// Ports:
//   clk        rising-edge clock
//   nreset     asynchronous active-low reset
//   din        parallel word to transmit
//   valid_in   din/datasize/lsbfirst valid; transfer on valid_in & ready_out
//   ready_out  pending buffer free, a word can be accepted this cycle
//   datasize   number of chunks to send minus one
//   lsbfirst   1 = emit low chunk first, 0 = emit high chunk first
//   fill       bit shifted into vacated shift-register positions
//   wait_in    downstream stall, freezes shifting while high
//   dout       current serial chunk
//   shift_out  dout valid this cycle
//   last_out   final chunk of a word (qualified by shift_out)
//   busy       shifter or pending buffer holds data

module oh_par2ser_tx #(
  parameter int PW = 64,
  parameter int SW = 1,
  parameter int CW = $clog2(PW/SW)
) (
  input  logic          clk,
  input  logic          nreset,
  input  logic [PW-1:0] din,
  input  logic          valid_in,
  output logic          ready_out,
  input  logic [CW-1:0] datasize,
  input  logic          lsbfirst,
  input  logic          fill,
  input  logic          wait_in,
  output logic [SW-1:0] dout,
  output logic          shift_out,
  output logic          last_out,
  output logic          busy
);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t        state;
  logic [PW-1:0] sreg;
  logic          order;
  logic [CW-1:0] count;
  logic [PW-1:0] pdin;
  logic [CW-1:0] psize;
  logic          plsb;
  logic          pending_valid;

  logic          accept;
  logic          advance;
  logic          done;
  logic [PW-1:0] sreg_shifted;

  // ready_out only looks at the pending buffer: the shifter is always able to
  // take a word or hand its own slot to the pending word at completion.
  assign ready_out = ~pending_valid;
  assign accept    = valid_in & ready_out;
  assign advance   = (state == SHIFT) & ~wait_in;
  assign done      = advance & (count == '0);

  assign shift_out = advance;
  assign last_out  = done;
  assign busy      = (state == SHIFT) | pending_valid;

  always_comb begin
    dout = '0;
    if (state == SHIFT) begin
      dout = order ? sreg[SW-1:0] : sreg[PW-1:PW-SW];
    end
  end

  // Shift toward whichever end is emitting.
  assign sreg_shifted = order ? {{SW{fill}}, sreg[PW-1:SW]}
                              : {sreg[PW-SW-1:0], {SW{fill}}};

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state         <= IDLE;
      sreg          <= '0;
      order         <= 1'b0;
      count         <= '0;
      pdin          <= '0;
      psize         <= '0;
      plsb          <= 1'b0;
      pending_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            sreg  <= din;
            count <= datasize;
            order <= lsbfirst;
            state <= SHIFT;
          end
        end
        SHIFT: begin
          if (done) begin
            // Pending word has priority; accept is impossible while it is held.
            if (pending_valid) begin
              sreg          <= pdin;
              count         <= psize;
              order         <= plsb;
              pending_valid <= 1'b0;
            end else if (accept) begin
              sreg  <= din;
              count <= datasize;
              order <= lsbfirst;
            end else begin
              state <= IDLE;
            end
          end else begin
            if (advance) begin
              sreg  <= sreg_shifted;
              count <= count - CW'(1);
            end
            if (accept) begin
              pdin          <= din;
              psize         <= datasize;
              plsb          <= lsbfirst;
              pending_valid <= 1'b1;
            end
          end
        end
      endcase
    end
  end

endmodule
